// File: rtl/hdmi_align_ctrl.sv
// Per-lane TMDS alignment: sweeps IDELAY taps and word phases, locks at the centre of the widest
// token eye, and re-acquires after token loss. Optional manual override: define HDMIALIGN_MANUAL_EN.
module hdmi_align_ctrl #(
  parameter int LGWIN         = 16,
  parameter int THRESH        = 2048,
  parameter int MINRUN        = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int LGLOSS        = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [9:0] i_word,
  input  logic [4:0] i_actual_delay,
`ifdef HDMIALIGN_MANUAL_EN
  input  logic       i_manual,
  input  logic [4:0] i_man_delay,
  input  logic [3:0] i_man_phase,
`endif
  output logic [4:0] o_delay,
  output logic [9:0] o_word,
  output logic [3:0] o_phase,
  output logic       o_locked
);

  // state       | meaning
  // SETTLE      | wait for the delay element to match and settle before a window
  // MEASURE     | count token hits over 2^LGWIN words
  // EVAL        | score tap, update run trackers, step tap
  // DECIDE      | pick eye centre or advance to the next phase
  // SETTLE_LOCK | settle on the chosen centre tap
  // LOCKED      | aligned; watch for token loss
  typedef enum logic [2:0] {
    ST_SETTLE, ST_MEASURE, ST_EVAL, ST_DECIDE, ST_SETTLE_LOCK, ST_LOCKED
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int HW = LGWIN + 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [HW-1:0] THRESH_W    = HW'(THRESH);
  localparam logic [5:0]    MINRUN_W    = 6'(MINRUN);

  state_t           state, state_nx;
  logic [9:0]       prev;
  logic [SW-1:0]    wait_cnt, wait_nx;
  logic [LGWIN-1:0] win_cnt, win_nx;
  logic [HW-1:0]    hit_cnt, hit_nx;
  logic [LGLOSS-1:0] loss_cnt, loss_nx;
  logic [4:0]       cur_start, cur_start_nx, best_start, best_start_nx;
  logic [5:0]       cur_len, cur_len_nx, best_len, best_len_nx;
  logic [4:0]       delay_nx;
  logic [3:0]       phase_nx;
  logic [4:0]       cls_start;
  logic [5:0]       cls_len;
  logic             tok_hit;
  logic [19:0]      h;

`ifdef HDMIALIGN_MANUAL_EN
  logic man_q;
`endif

  assign h       = {i_word, prev};
  assign tok_hit = (o_word == 10'h354) || (o_word == 10'h0AB) ||
                   (o_word == 10'h154) || (o_word == 10'h2AB);

  // Closing a run: strictly longer replaces best, so the lowest-tap run wins ties.
  assign cls_len   = (cur_len > best_len) ? cur_len   : best_len;
  assign cls_start = (cur_len > best_len) ? cur_start : best_start;

  always_comb begin
    state_nx      = state;
    delay_nx      = o_delay;
    phase_nx      = o_phase;
    wait_nx       = wait_cnt;
    win_nx        = win_cnt;
    hit_nx        = hit_cnt;
    loss_nx       = loss_cnt;
    cur_start_nx  = cur_start;
    cur_len_nx    = cur_len;
    best_start_nx = best_start;
    best_len_nx   = best_len;

    case (state)
      ST_SETTLE, ST_SETTLE_LOCK: begin
        if (i_actual_delay != o_delay) begin
          wait_nx = SETTLE_LOAD;
        end else if (wait_cnt == '0) begin
          state_nx = (state == ST_SETTLE) ? ST_MEASURE : ST_LOCKED;
          win_nx   = '1;
          hit_nx   = '0;
          loss_nx  = '0;
        end else begin
          wait_nx = wait_cnt - 1'b1;
        end
      end
      ST_MEASURE: begin
        if (tok_hit) hit_nx = hit_cnt + 1'b1;
        if (win_cnt == '0) state_nx = ST_EVAL;
        else               win_nx   = win_cnt - 1'b1;
      end
      ST_EVAL: begin
        if (hit_cnt >= THRESH_W) begin
          if (cur_len == '0) cur_start_nx = o_delay;
          cur_len_nx = cur_len + 6'd1;
        end else begin
          best_len_nx   = cls_len;
          best_start_nx = cls_start;
          cur_len_nx    = '0;
        end
        if (o_delay == 5'd31) begin
          state_nx = ST_DECIDE;
        end else begin
          delay_nx = o_delay + 5'd1;
          wait_nx  = SETTLE_LOAD;
          state_nx = ST_SETTLE;
        end
      end
      ST_DECIDE: begin
        if (cls_len >= MINRUN_W) begin
          delay_nx = cls_start + cls_len[5:1];
          state_nx = ST_SETTLE_LOCK;
        end else begin
          phase_nx = (o_phase == 4'd9) ? 4'd0 : o_phase + 4'd1;
          delay_nx = '0;
          state_nx = ST_SETTLE;
        end
        cur_len_nx  = '0;
        best_len_nx = '0;
        wait_nx     = SETTLE_LOAD;
      end
      ST_LOCKED: begin
        if (tok_hit) begin
          loss_nx = '0;
        end else if (loss_cnt == '1) begin
          state_nx    = ST_SETTLE;
          delay_nx    = '0;
          phase_nx    = '0;
          cur_len_nx  = '0;
          best_len_nx = '0;
          wait_nx     = SETTLE_LOAD;
        end else begin
          loss_nx = loss_cnt + 1'b1;
        end
      end
      default: state_nx = ST_SETTLE;
    endcase

`ifdef HDMIALIGN_MANUAL_EN
    if (i_manual || man_q) begin
      state_nx    = ST_SETTLE;
      wait_nx     = SETTLE_LOAD;
      cur_len_nx  = '0;
      best_len_nx = '0;
      delay_nx    = i_manual ? i_man_delay : 5'd0;
      phase_nx    = !i_manual ? 4'd0 : (i_man_phase > 4'd9) ? 4'd9 : i_man_phase;
    end
`endif
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= ST_SETTLE;
      prev       <= '0;
      o_word     <= '0;
      o_delay    <= '0;
      o_phase    <= '0;
      o_locked   <= 1'b0;
      wait_cnt   <= SETTLE_LOAD;
      win_cnt    <= '1;
      hit_cnt    <= '0;
      loss_cnt   <= '0;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
    end else begin
      state      <= state_nx;
      prev       <= i_word;
      o_word     <= 10'(h >> o_phase);
      o_delay    <= delay_nx;
      o_phase    <= phase_nx;
      o_locked   <= (state_nx == ST_LOCKED);
      wait_cnt   <= wait_nx;
      win_cnt    <= win_nx;
      hit_cnt    <= hit_nx;
      loss_cnt   <= loss_nx;
      cur_start  <= cur_start_nx;
      cur_len    <= cur_len_nx;
      best_start <= best_start_nx;
      best_len   <= best_len_nx;
    end
  end

`ifdef HDMIALIGN_MANUAL_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) man_q <= 1'b0;
    else            man_q <= i_manual;
  end
`endif

endmodule
